// File: rtl/lfo_if.sv
// Control/sample bundle for lfo_core: sample-rate strobe, waveform controls and the output sample.
interface lfo_if;
    logic       sample_clk;
    logic [1:0] wave_type;
    logic [9:0] frequency_in;
    logic [9:0] pulse_width;
    logic [9:0] d_out;

    modport master (
        output sample_clk,
        output wave_type,
        output frequency_in,
        output pulse_width,
        input  d_out
    );

    modport slave (
        input  sample_clk,
        input  wave_type,
        input  frequency_in,
        input  pulse_width,
        output d_out
    );
endinterface

// File: rtl/lfo_core.sv
// lfo_core: sample-tick driven LFO (square/triangle/saw/sine); d_out updates 4 clk after a sample_clk rise, no backpressure.
// Sine quarter-wave table exists only with LFO_SINE_EN defined; otherwise wave_type 11 holds midscale 512.
module lfo_core (
    input  logic  clk,
    input  logic  reset_n,
    lfo_if.slave  lfo
);

    localparam logic [1:0] WAVE_SQUARE = 2'b00;
    localparam logic [1:0] WAVE_TRI    = 2'b01;
    localparam logic [1:0] WAVE_SAW    = 2'b10;

`ifdef LFO_SINE_EN
    // Q[k] = round(511*sin(2*pi*(k+0.5)/1024)), packed 9 bits per entry.
    function automatic logic [256*9-1:0] build_sine_tbl();
        logic [256*9-1:0] tbl;
        real              val;
        tbl = '0;
        for (int k = 0; k < 256; k++) begin
            val = 511.0 * $sin(2.0 * 3.14159265358979 * (k + 0.5) / 1024.0);
            tbl[k*9 +: 9] = 9'($rtoi(val + 0.5));
        end
        return tbl;
    endfunction

    localparam logic [256*9-1:0] SINE_Q = build_sine_tbl();
`endif

    logic [2:0]  sync_q;
    logic [2:0]  sync_d;
    logic        tick;
    logic [19:0] phase_q;
    logic [19:0] phase_d;
    logic        upd_q;
    logic        upd_d;
    logic [9:0]  d_out_q;
    logic [9:0]  d_out_d;

    logic [9:0]  p;
    logic [9:0]  tri_ramp;
    logic [9:0]  square_val;
    logic [9:0]  tri_val;
    logic [9:0]  sine_val;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] remembers the previous synchronized level.
    assign sync_d = {sync_q[1], sync_q[0], lfo.sample_clk};
    assign tick   = sync_q[1] & ~sync_q[2];
    assign upd_d  = tick;

    always_comb begin
        phase_d = phase_q;
        if (tick) begin
            phase_d = phase_q + {10'd0, lfo.frequency_in} + 20'd1;
        end
    end

    assign p          = phase_q[19:10];
    assign tri_ramp   = {p[8:0], 1'b0};
    assign square_val = (p < lfo.pulse_width) ? 10'd1023 : 10'd0;
    assign tri_val    = p[9] ? ~tri_ramp : tri_ramp;

`ifdef LFO_SINE_EN
    logic [7:0] sine_k;
    logic [8:0] sine_q;
    assign sine_k   = p[8] ? ~p[7:0] : p[7:0];
    assign sine_q   = SINE_Q[sine_k*9 +: 9];
    assign sine_val = p[9] ? (10'd511 - {1'b0, sine_q}) : (10'd512 + {1'b0, sine_q});
`else
    assign sine_val = 10'd512;
`endif

    // Controls are only looked at in the cycle after the phase step, so d_out never moves between ticks.
    always_comb begin
        d_out_d = d_out_q;
        if (upd_q) begin
            case (lfo.wave_type)
                WAVE_SQUARE: d_out_d = square_val;
                WAVE_TRI:    d_out_d = tri_val;
                WAVE_SAW:    d_out_d = p;
                default:     d_out_d = sine_val;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 3'b000;
            phase_q <= 20'd0;
            upd_q   <= 1'b0;
            d_out_q <= 10'd0;
        end else begin
            sync_q  <= sync_d;
            phase_q <= phase_d;
            upd_q   <= upd_d;
            d_out_q <= d_out_d;
        end
    end

    assign lfo.d_out = d_out_q;

endmodule

// File: tb/tb_lfo_core.sv
// Scoreboard bench for lfo_core: a phase/waveform model pushes the expected sample per tick, popped once d_out has settled.
module tb_lfo_core;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    lfo_if bus ();

    lfo_core dut (
        .clk     (clk),
        .reset_n (reset_n),
        .lfo     (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_q[$];
    logic [19:0] m_phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic [1:0] wt, input logic [9:0] p, input logic [9:0] pw);
        int r;
        int k;
        int q;
        r = 0;
        k = 0;
        q = 0;
        case (wt)
            2'b00: r = (p < pw) ? 1023 : 0;
            2'b01: begin
                r = 2 * int'(p % 512);
                if (p >= 512) r = 1023 - r;
            end
            2'b10: r = int'(p);
            default: begin
`ifdef LFO_SINE_EN
                k = int'(p % 256);
                if ((p % 512) >= 256) k = 255 - k;
                q = $rtoi(511.0 * $sin(2.0 * 3.14159265358979 * (k + 0.5) / 1024.0) + 0.5);
                r = (p >= 512) ? (511 - q) : (512 + q);
`else
                r = 512;
`endif
            end
        endcase
        return r;
    endfunction

    task automatic do_tick(input string tag, input logic [1:0] wt, input int f, input int pw);
        int e;
        @(negedge clk);
        bus.wave_type    = wt;
        bus.frequency_in = 10'(f);
        bus.pulse_width  = 10'(pw);
        bus.sample_clk   = 1'b1;
        m_phase = m_phase + 20'(f + 1);
        exp_q.push_back(model(wt, m_phase[19:10], 10'(pw)));
        repeat (4) @(negedge clk);
        bus.sample_clk = 1'b0;
        repeat (4) @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.d_out, e);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("rst_mid_async", bus.d_out, 0);
        repeat (3) @(negedge clk);
        check("rst_mid_hold", bus.d_out, 0);
        reset_n = 1'b1;
        m_phase = 20'd0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n          = 1'b0;
        bus.sample_clk   = 1'b0;
        bus.wave_type    = 2'b00;
        bus.frequency_in = 10'd0;
        bus.pulse_width  = 10'd0;
        m_phase          = 20'd0;

        for (int i = 0; i < 5; i++) begin
            #10 bus.sample_clk = ~bus.sample_clk;
            check("rst_hold", bus.d_out, 0);
        end
        bus.sample_clk = 1'b0;
        #10;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst", bus.d_out, 0);

        do_tick("first_tick", 2'b10, 1023, 0);

        for (int i = 0; i < 600; i++)  do_tick("sq_pw800", 2'b00, 512, 800);
        for (int i = 0; i < 20; i++)   do_tick("sq_pw0", 2'b00, 1023, 0);
        for (int i = 0; i < 1100; i++) do_tick("sq_pw1023", 2'b00, 1023, 1023);
        for (int i = 0; i < 2100; i++) do_tick("tri", 2'b01, 512, 0);
        for (int i = 0; i < 1030; i++) do_tick("saw", 2'b10, 1023, 0);
`ifdef LFO_SINE_EN
        for (int i = 0; i < 2100; i++) do_tick("sine", 2'b11, 512, 0);
`else
        for (int i = 0; i < 40; i++)   do_tick("sine_off", 2'b11, 512, 0);
`endif
        for (int i = 0; i < 10; i++)   do_tick("switch_sq", 2'b00, 512, 800);
        for (int i = 0; i < 10; i++)   do_tick("switch_saw", 2'b10, 512, 800);

        mid_reset();
        do_tick("after_mid_rst", 2'b10, 700, 0);

        for (int i = 0; i < 40; i++) begin
            do_tick("random", 2'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)));
        end

        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
